// File: rtl/mul_pkg.sv
// mul_pkg: shared FSM states, Booth digit codes and width helpers for the sequential multiplier.
package mul_pkg;
  localparam int DEF_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} digit_e;
  function automatic digit_e booth_digit(input logic [2:0] w);
    return (w == 3'b001 || w == 3'b010) ? POS1 :
           (w == 3'b011) ? POS2 :
           (w == 3'b100) ? NEG2 :
           (w == 3'b101 || w == 3'b110) ? NEG1 : ZERO;
  endfunction
  function automatic int cnt_width(input int steps);
    return steps > 1 ? $clog2(steps) : 1;
  endfunction
endpackage

// File: rtl/booth_recoder.sv
// booth_recoder: maps a radix-4 Booth window onto a sign-extended partial product of M.
module booth_recoder import mul_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2:0]       win_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH+1:0] pp_o
);
  digit_e digit;
  logic [WIDTH+1:0] m1, m2;
  assign digit = booth_digit(win_i);
  assign m1 = {{2{m_i[WIDTH-1]}}, m_i};
  assign m2 = {m_i[WIDTH-1], m_i, 1'b0};
  always_comb begin
    pp_o = (digit == POS1) ? m1 :
           (digit == POS2) ? m2 :
           (digit == NEG1) ? -m1 :
           (digit == NEG2) ? -m2 : '0;
  end
endmodule

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential radix-4 Booth signed multiplier feeding the HI/LO registers.
module booth_mul_seq import mul_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic             hilo_load,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);
  localparam int STEPS = WIDTH / 2;
  localparam int CW = cnt_width(STEPS);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] m_q, m_d, q_q, q_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH+1:0] acc_q, acc_d, pp, sum;
  logic qm1_q, qm1_d, last;
  booth_recoder #(.WIDTH(WIDTH)) u_rec (
    .win_i({q_q[1:0], qm1_q}),
    .m_i  (m_q),
    .pp_o (pp)
  );
  assign sum = acc_q + pp;
  assign last = cnt_q == CW'(STEPS - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    m_d = m_q;
    q_d = q_q;
    qm1_d = qm1_q;
    acc_d = acc_q;
    hi_d = hi_q;
    lo_d = lo_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        m_d = multiplicand;
        q_d = multiplier;
        qm1_d = 1'b0;
        acc_d = '0;
        cnt_d = '0;
      end
      RUN: begin
        // accumulator and multiplier shift right by 2 as one combined register
        acc_d = {{2{sum[WIDTH+1]}}, sum[WIDTH+1:2]};
        q_d = {sum[1:0], q_q[WIDTH-1:2]};
        qm1_d = q_q[1];
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          hi_d = acc_d[WIDTH-1:0];
          lo_d = q_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      cnt_q <= '0;
      m_q <= '0;
      q_q <= '0;
      qm1_q <= 1'b0;
      acc_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      m_q <= m_d;
      q_q <= q_d;
      qm1_q <= qm1_d;
      acc_q <= acc_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign hilo_load = done;
  assign product_hi = hi_q;
  assign product_lo = lo_q;
endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: directed and randomised checks of the sequential Booth multiplier.
module tb_booth_mul_seq;
  logic clk = 1'b0;
  logic clear, start;
  logic [31:0] multiplicand, multiplier;
  logic busy, done, hilo_load;
  logic [31:0] product_hi, product_lo;
  int errors = 0;
  int checks = 0;
  booth_mul_seq #(.WIDTH(32)) dut (
    .clk(clk), .clear(clear), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .hilo_load(hilo_load),
    .product_hi(product_hi), .product_lo(product_lo)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    check("hilo_eq_done", 64'(hilo_load), 64'(done));
  endtask
  task automatic mul(input logic [31:0] m, input logic [31:0] q, input logic [63:0] exp, input string tag);
    int n;
    multiplicand = m;
    multiplier = q;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd16);
    check({tag, "_product"}, {product_hi, product_lo}, exp);
    tick();
    check({tag, "_end"}, {62'd0, busy, done}, 64'd0);
  endtask
  initial begin
    int dones, first, second;
    logic [31:0] rm, rq;
    logic [63:0] rexp;
    clear = 1'b0;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    #12;
    check("rst_outs", {61'd0, busy, done, hilo_load}, 64'd0);
    check("rst_prod", {product_hi, product_lo}, 64'd0);
    clear = 1'b1;
    tick();
    mul(32'd3, 32'd5, 64'h0000_0000_0000_000F, "m3x5");
    mul(32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, "mneg7x6");
    mul(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "min_x_min");
    mul(32'h7FFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0001, "max_x_neg1");
    // starts arriving mid-run and on the DONE cycle must be dropped
    multiplicand = 32'd2;
    multiplier = 32'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    multiplicand = 32'd9;
    multiplier = 32'd9;
    dones = 0;
    for (int c = 1; c <= 30; c++) begin
      start = (c == 5 || c == 16);
      tick();
      if (done) dones++;
    end
    start = 1'b0;
    check("ignored_start_dones", 64'(dones), 64'd1);
    check("ignored_start_prod", {product_hi, product_lo}, 64'd6);
    check("ignored_start_idle", 64'(busy), 64'd0);
    first = -1;
    second = -1;
    start = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      tick();
      if (done && first < 0) first = c;
      else if (done && second < 0) second = c;
    end
    start = 1'b0;
    check("b2b_first", 64'(first), 64'd17);
    check("b2b_spacing", 64'(second - first), 64'd18);
    check("b2b_prod", {product_hi, product_lo}, 64'd81);
    for (int c = 0; c < 40 && busy; c++) tick();
    check("b2b_drain", 64'(busy), 64'd0);
    multiplicand = 32'd10;
    multiplier = 32'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    #2 clear = 1'b0;
    #1;
    check("async_clr_busy", {62'd0, busy, done}, 64'd0);
    check("async_clr_prod", {product_hi, product_lo}, 64'd0);
    #3 clear = 1'b1;
    dones = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (done) dones++;
    end
    check("async_clr_no_done", 64'(dones), 64'd0);
    check("async_clr_idle", 64'(busy), 64'd0);
    mul(32'd4, 32'd4, 64'd16, "m4x4");
    for (int i = 0; i < 1000; i++) begin
      rm = $urandom;
      rq = $urandom;
      rexp = $signed({{32{rm[31]}}, rm}) * $signed({{32{rq[31]}}, rq});
      mul(rm, rq, rexp, "rnd");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
